// File: rtl/riscv_mem_pkg.sv
// Shared constants for the data memory / MMIO block.
// Holds the MMIO register offsets (word index addr[4:2]) and the STATUS bit positions.
// Imported by data_mem_resp and mmio_regs.
package riscv_mem_pkg;

  localparam logic [2:0] MMIO_OFF_LED    = 3'd0;
  localparam logic [2:0] MMIO_OFF_CYCLE  = 3'd1;
  localparam logic [2:0] MMIO_OFF_TCMP   = 3'd2;
  localparam logic [2:0] MMIO_OFF_STATUS = 3'd3;

  localparam int STATUS_IRQ_BIT = 0;
  localparam int STATUS_ERR_BIT = 1;

endpackage

// File: rtl/mmio_regs.sv
// MMIO register file: LED, free-running CYCLE, timer compare TCMP, and STATUS (sticky irq/err, W1C).
// Ports: clk, rst (async active-low); i_wr = aligned MMIO store, i_misalign = any misaligned store,
//        i_off/i_wdata = register offset and data; o_rdata is combinational; o_led/o_irq/o_err are registered.
module mmio_regs
  import riscv_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr,
  input  logic        i_misalign,
  input  logic [2:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [15:0] o_led,
  output logic        o_irq,
  output logic        o_err
);

  logic [31:0] r_led;
  logic [31:0] r_cycle;
  logic [31:0] r_tcmp;
  logic        r_irq;
  logic        r_err;

  logic        w_wr_led;
  logic        w_wr_cycle;
  logic        w_wr_tcmp;
  logic        w_wr_status;
  logic        w_irq_set;
  logic        w_irq_clr;
  logic        w_err_clr;

  assign w_wr_led    = i_wr && (i_off == MMIO_OFF_LED);
  assign w_wr_cycle  = i_wr && (i_off == MMIO_OFF_CYCLE);
  assign w_wr_tcmp   = i_wr && (i_off == MMIO_OFF_TCMP);
  // i_wr is only asserted for aligned stores, so a misaligned STATUS store never clears.
  assign w_wr_status = i_wr && (i_off == MMIO_OFF_STATUS);

  // Match against the pre-increment CYCLE value; TCMP of zero disables matching.
  assign w_irq_set = (r_tcmp != 32'd0) && (r_cycle == r_tcmp);
  assign w_irq_clr = w_wr_status && i_wdata[STATUS_IRQ_BIT];
  assign w_err_clr = w_wr_status && i_wdata[STATUS_ERR_BIT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_led   <= 32'd0;
      r_cycle <= 32'd0;
      r_tcmp  <= 32'd0;
      r_irq   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_wr_led)  r_led  <= i_wdata;
      if (w_wr_tcmp) r_tcmp <= i_wdata;
      // A software write to CYCLE takes priority over the increment.
      if (w_wr_cycle) r_cycle <= i_wdata;
      else            r_cycle <= r_cycle + 32'd1;
      // Set wins over a same-cycle W1C.
      r_irq <= w_irq_set  || (r_irq && !w_irq_clr);
      r_err <= i_misalign || (r_err && !w_err_clr);
    end
  end

  always_comb begin
    o_rdata = 32'd0;
    case (i_off)
      MMIO_OFF_LED:    o_rdata = r_led;
      MMIO_OFF_CYCLE:  o_rdata = r_cycle;
      MMIO_OFF_TCMP:   o_rdata = r_tcmp;
      MMIO_OFF_STATUS: o_rdata = {30'd0, r_err, r_irq};
      default:         o_rdata = 32'd0;
    endcase
  end

  assign o_led = r_led[15:0];
  assign o_irq = r_irq;
  assign o_err = r_err;

endmodule

// File: rtl/data_mem_resp.sv
// Data memory for a single-cycle core: word RAM plus an MMIO window selected by addr[MMIO_BASE_BIT].
// Ports: clk, rst (async active-low), memwrite/addr/writedata from the core; readdata is combinational
//        from addr (old value during a store cycle); led/irq/err come from the MMIO register block.
module data_mem_resp
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH         = 256,
  parameter int MMIO_BASE_BIT = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [15:0] led,
  output logic        irq,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   r_ram [DEPTH];

  logic          w_is_mmio;
  logic          w_misalign;
  logic          w_aligned_wr;
  logic          w_ram_we;
  logic [AW-1:0] w_word_idx;
  logic [31:0]   w_mmio_rdata;
  logic          w_unused_addr;

  assign w_is_mmio    = addr[MMIO_BASE_BIT];
  assign w_misalign   = memwrite && (addr[1:0] != 2'b00);
  assign w_aligned_wr = memwrite && (addr[1:0] == 2'b00);
  // Bits above the word index are deliberately ignored so RAM aliases modulo DEPTH*4.
  assign w_word_idx   = addr[AW+1:2];
  // RAM is not reset, so stores must be explicitly blocked while rst is held low.
  assign w_ram_we     = w_aligned_wr && !w_is_mmio && rst;
  assign w_unused_addr = ^addr;

  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[w_word_idx] <= writedata;
  end

  mmio_regs u_mmio_regs (
    .clk        (clk),
    .rst        (rst),
    .i_wr       (w_aligned_wr && w_is_mmio),
    .i_misalign (w_misalign),
    .i_off      (addr[4:2]),
    .i_wdata    (writedata),
    .o_rdata    (w_mmio_rdata),
    .o_led      (led),
    .o_irq      (irq),
    .o_err      (err)
  );

  assign readdata = w_is_mmio ? w_mmio_rdata : r_ram[w_word_idx];

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: table of single-cycle accesses with a read-data scoreboard,
// plus hand sequences for reset, timer match, W1C-vs-set and asynchronous reset.
module tb_data_mem_resp;

  logic        clk;
  logic        rst;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] led;
  logic        irq;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] sb_q [$];

  localparam logic [31:0] A_LED    = 32'h8000_0000;
  localparam logic [31:0] A_CYCLE  = 32'h8000_0004;
  localparam logic [31:0] A_TCMP   = 32'h8000_0008;
  localparam logic [31:0] A_STATUS = 32'h8000_000C;

  data_mem_resp #(.DEPTH(256), .MMIO_BASE_BIT(31)) dut (
    .clk       (clk),
    .rst       (rst),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .led       (led),
    .irq       (irq),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp_rd;
    logic [15:0] exp_led;
    logic        exp_err;
  } vec_t;

  vec_t vecs [27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one access; leaves time mid-cycle, away from either edge.
  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd);
    memwrite  = we;
    addr      = a;
    writedata = wd;
    #4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: expected read pushed at drive time, popped when readdata is sampled.
  task automatic expect_rd(input logic [31:0] exp);
    sb_q.push_back(exp);
  endtask

  task automatic pop_rd(input string name);
    logic [31:0] e;
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check(name, readdata, e);
    end
  endtask

  task automatic setv(input int i, input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic chk, input logic [31:0] rd, input logic [15:0] l, input logic e);
    vecs[i].we = we; vecs[i].a = a; vecs[i].wd = wd; vecs[i].chk = chk;
    vecs[i].exp_rd = rd; vecs[i].exp_led = l; vecs[i].exp_err = e;
  endtask

  initial begin
    int   waited;
    logic got;

    setv( 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0,          16'h0,    0);
    setv( 1, 0, 32'h0000_0010, 32'h0,         1, 32'hDEAD_BEEF,  16'h0,    0);
    setv( 2, 0, 32'h0000_0410, 32'h0,         1, 32'hDEAD_BEEF,  16'h0,    0);
    setv( 3, 0, 32'h0000_0013, 32'h0,         1, 32'hDEAD_BEEF,  16'h0,    0);
    setv( 4, 1, 32'h0000_0010, 32'h1234_5678, 1, 32'hDEAD_BEEF,  16'h0,    0);
    setv( 5, 0, 32'h0000_0010, 32'h0,         1, 32'h1234_5678,  16'h0,    0);
    setv( 6, 1, 32'h0000_0004, 32'hCAFE_F00D, 0, 32'h0,          16'h0,    0);
    setv( 7, 1, 32'h0000_0006, 32'h0BAD_BAD0, 1, 32'hCAFE_F00D,  16'h0,    0);
    setv( 8, 0, 32'h0000_0004, 32'h0,         1, 32'hCAFE_F00D,  16'h0,    1);
    setv( 9, 0, A_STATUS,      32'h0,         1, 32'h0000_0002,  16'h0,    1);
    setv(10, 1, A_STATUS,      32'h0000_0002, 1, 32'h0000_0002,  16'h0,    1);
    setv(11, 0, A_STATUS,      32'h0,         1, 32'h0,          16'h0,    0);
    setv(12, 1, A_LED,         32'h0000_ABCD, 1, 32'h0,          16'h0,    0);
    setv(13, 0, A_LED,         32'h0,         1, 32'h0000_ABCD,  16'hABCD, 0);
    setv(14, 0, 32'h8000_0010, 32'h0,         1, 32'h0,          16'hABCD, 0);
    setv(15, 1, 32'h8000_0014, 32'hFFFF_FFFF, 1, 32'h0,          16'hABCD, 0);
    setv(16, 0, 32'h8000_0014, 32'h0,         1, 32'h0,          16'hABCD, 0);
    setv(17, 0, 32'h8000_0020, 32'h0,         1, 32'h0000_ABCD,  16'hABCD, 0);
    setv(18, 1, A_TCMP,        32'hFFFF_0000, 1, 32'h0,          16'hABCD, 0);
    setv(19, 1, A_TCMP,        32'h0,         1, 32'hFFFF_0000,  16'hABCD, 0);
    setv(20, 0, A_TCMP,        32'h0,         1, 32'h0,          16'hABCD, 0);
    setv(21, 1, A_CYCLE,       32'hFFFF_FFFE, 0, 32'h0,          16'hABCD, 0);
    setv(22, 0, A_CYCLE,       32'h0,         1, 32'hFFFF_FFFE,  16'hABCD, 0);
    setv(23, 0, A_CYCLE,       32'h0,         1, 32'hFFFF_FFFF,  16'hABCD, 0);
    setv(24, 0, A_CYCLE,       32'h0,         1, 32'h0,          16'hABCD, 0);
    setv(25, 1, A_STATUS,      32'h0000_0003, 1, 32'h0,          16'hABCD, 0);
    setv(26, 0, 32'h0001_0010, 32'h0,         1, 32'h1234_5678,  16'hABCD, 0);

    // Reset phase, with a store to LED that must be ignored.
    rst = 1'b0; memwrite = 1'b0; addr = 32'h0; writedata = 32'h0;
    tick();
    drive(1, A_LED, 32'h0000_5555);
    check("rst_led", {16'd0, led}, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    check("rst_err", {31'd0, err}, 32'h0);
    tick();
    drive(0, A_LED, 32'h0);
    check("rst_led_rd", readdata, 32'h0);
    check("rst_led_after_edge", {16'd0, led}, 32'h0);
    tick();

    // Release reset between edges: CYCLE reads 0, then 1 after the first edge.
    rst = 1'b1;
    drive(0, A_CYCLE, 32'h0);
    check("cycle_before_first_edge", readdata, 32'h0);
    tick();
    drive(0, A_CYCLE, 32'h0);
    check("cycle_after_first_edge", readdata, 32'h1);
    tick();

    for (int i = 0; i < 27; i++) begin
      drive(vecs[i].we, vecs[i].a, vecs[i].wd);
      if (vecs[i].chk) expect_rd(vecs[i].exp_rd);
      if (vecs[i].chk) pop_rd($sformatf("vec%0d_rd", i));
      check($sformatf("vec%0d_led", i), {16'd0, led}, {16'd0, vecs[i].exp_led});
      check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d_irq", i), {31'd0, irq}, 32'h0);
      tick();
    end

    // Timer match before the mid-run reset: CYCLE=0x100, TCMP=0x103.
    drive(1, A_CYCLE, 32'h0000_0100); tick();
    drive(1, A_TCMP,  32'h0000_0103); tick();
    got = 1'b0;
    waited = 0;
    while (!got && waited < 10) begin
      drive(0, A_CYCLE, 32'h0);
      if (irq) got = 1'b1;
      else begin tick(); waited++; end
    end
    check("irq_seen_pre_reset", {31'd0, got}, 32'h1);
    check("irq_first_cycle_val", readdata, 32'h0000_0104);
    tick();

    drive(1, A_LED, 32'h0000_1234);       tick();
    drive(1, 32'h0000_0014, 32'h0000_AAAA); tick();
    drive(1, 32'h0000_0021, 32'h0);        tick();
    drive(0, A_STATUS, 32'h0);
    check("pre_rst_led", {16'd0, led}, 32'h0000_1234);
    check("pre_rst_status", readdata, 32'h0000_0003);

    // Asynchronous reset mid-cycle: outputs clear without an edge.
    rst = 1'b0;
    #1;
    check("async_led", {16'd0, led}, 32'h0);
    check("async_irq", {31'd0, irq}, 32'h0);
    check("async_err", {31'd0, err}, 32'h0);
    tick();
    drive(1, 32'h0000_0014, 32'h0000_1111);
    tick();
    drive(1, A_LED, 32'h0000_7777);
    tick();

    rst = 1'b1;
    drive(0, A_CYCLE, 32'h0);
    check("rel_cycle0", readdata, 32'h0);
    tick();                                   // CYCLE 0->1
    drive(0, A_CYCLE, 32'h0);
    check("rel_cycle1", readdata, 32'h1);
    tick();                                   // 1->2
    drive(0, 32'h0000_0014, 32'h0);
    expect_rd(32'h0000_AAAA);
    pop_rd("ram_write_in_reset_ignored");
    tick();                                   // 2->3
    drive(1, A_TCMP, 32'd20);
    check("led_after_rst_writes", {16'd0, led}, 32'h0);
    tick();                                   // 3->4, TCMP=20

    waited = 0;
    drive(0, A_CYCLE, 32'h0);
    while (readdata != 32'd20 && waited < 40) begin
      if (irq) check("irq_early", {31'd0, irq}, 32'h0);
      tick();
      waited++;
      drive(0, A_CYCLE, 32'h0);
    end
    check("cycle_reached_20", readdata, 32'd20);
    check("irq_before_match_edge", {31'd0, irq}, 32'h0);
    // W1C of irq in the same cycle as the fresh match: set must win.
    drive(1, A_STATUS, 32'h0000_0001);
    tick();
    drive(0, A_CYCLE, 32'h0);
    check("irq_set_wins", {31'd0, irq}, 32'h1);
    check("cycle_21", readdata, 32'd21);
    tick();
    drive(1, A_STATUS, 32'h0000_0001);
    tick();
    drive(0, A_STATUS, 32'h0);
    check("irq_w1c", {31'd0, irq}, 32'h0);
    check("status_clear", readdata, 32'h0);
    // Misaligned STATUS store sets err and clears nothing.
    tick();
    drive(1, A_TCMP, 32'h0); tick();
    drive(1, A_CYCLE, 32'd50); tick();
    drive(1, A_TCMP, 32'd51); tick();       // compares 51 vs 51 at next edge
    drive(0, A_STATUS, 32'h0); tick();
    drive(1, A_STATUS | 32'h1, 32'h0000_0003);
    check("irq_before_misalign", {31'd0, irq}, 32'h1);
    tick();
    drive(0, A_STATUS, 32'h0);
    check("misalign_status", readdata, 32'h0000_0003);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DEPTH, default 256, is the number of RAM words (power of two).
REQ-002 Parameter MMIO_BASE_BIT, default 31, is the address bit that selects MMIO (1) or RAM (0).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 memwrite  input  1  store strobe from the core, valid for the whole cycle.
REQ-006 addr  input  32  byte address from the core (ALU result).
REQ-007 writedata  input  32  store data.
REQ-008 readdata  output  32  load data, combinational from addr.
REQ-009 led  output  16  LED register low half.
REQ-010 irq  output  1  sticky timer-match flag.
REQ-011 err  output  1  sticky misaligned-store flag.

Function
REQ-012 The block SHALL decode addr[MMIO_BASE_BIT]=0 as RAM, word index addr[log2(DEPTH)+1:2]; higher bits SHALL be ignored, so addresses wrap modulo DEPTH*4.
REQ-013 The block SHALL decode addr[MMIO_BASE_BIT]=1 as MMIO, register offset addr[4:2]: 0 LED, 1 CYCLE, 2 TCMP, 3 STATUS; offsets 4-7 SHALL read 0 and ignore writes.
REQ-014 readdata SHALL be zero-latency (same cycle as addr), since the core is single-cycle; addr[1:0] SHALL be ignored on reads and no error raised.
REQ-015 A write SHALL take effect at the rising edge where memwrite=1; a read of the same location in that cycle SHALL return the old value, the next cycle the new value.
REQ-016 memwrite=1 with addr[1:0]!=0 SHALL suppress the write entirely and set err at that edge.
REQ-017 LED SHALL be a 32-bit R/W register; led SHALL equal LED[15:0].
REQ-018 CYCLE SHALL increment by 1 every cycle, wrapping 0xFFFFFFFF->0; a CYCLE write SHALL load writedata and win over the increment that cycle.
REQ-019 TCMP SHALL be a 32-bit R/W register; when TCMP!=0 and CYCLE==TCMP (pre-increment value), irq SHALL set at that edge; TCMP=0 disables matching.
REQ-020 STATUS SHALL read {30'b0, err, irq}; writes are write-1-to-clear per bit, write-0 has no effect.
REQ-021 Set and W1C clear of the same status bit in the same cycle SHALL leave the bit set (set wins).
REQ-022 A misaligned write to STATUS SHALL set err and SHALL NOT clear any bit.

Reset
REQ-023 rst low SHALL asynchronously clear LED, CYCLE, TCMP, irq and err to 0; led, irq and err outputs SHALL be 0 while rst is low.
REQ-024 RAM contents SHALL NOT be reset; reads of unwritten RAM return undefined data.
REQ-025 CYCLE SHALL count from 0 on the first rising edge after rst deasserts, reading 1 after that edge.
REQ-026 Writes with memwrite=1 while rst is low SHALL be ignored.

Structure
REQ-027 A shared package riscv_mem_pkg SHALL hold MMIO offset constants (LED, CYCLE, TCMP, STATUS) and STATUS bit positions (IRQ=0, ERR=1).
REQ-028 MMIO registers SHALL live in one sub-module mmio_regs; RAM array and decode stay in data_mem_resp.

Verification
REQ-029 Write 0xDEADBEEF to 0x00000010, then read 0x00000010 and 0x00000410 (DEPTH=256) -> both return 0xDEADBEEF next cycle; same-cycle read returns the old value.
REQ-030 Store to 0x00000006 -> RAM word 1 unchanged, err=1, STATUS reads 0x2; write 0x2 to STATUS -> err=0.
REQ-031 Write 0x0000ABCD to LED (0x80000000) -> led=0xABCD next cycle; read returns 0x0000ABCD.
REQ-032 Write 0xFFFFFFFE to CYCLE -> reads 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 on successive cycles.
REQ-033 Write TCMP=20 after reset -> irq rises at edge where CYCLE 20->21; W1C on STATUS bit0 in the same cycle as a fresh match leaves irq=1.
REQ-034 Assert rst mid-run with LED=0x1234, irq=1 -> led, irq, err go 0 immediately without a clock edge.
